// File: rtl/divider_fp.sv
// Iterative IEEE-754 single-precision divider (restoring, one quotient bit per cycle, RNE).
// Optional macro DIVIDER_FP_DBZ_EN adds the divide-by-zero flag output dbz.
module divider_fp (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        ready,
    output logic [31:0] Y
`ifdef DIVIDER_FP_DBZ_EN
    ,
    output logic        dbz
`endif
);

    localparam logic [31:0] NAN_VALUE = 32'h7F80_0001;
    localparam int          Q_BITS    = 27;
    localparam logic [4:0]  CNT_LAST  = 5'(Q_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECKS,
        S_DIVIDE,
        S_NORMALIZE,
        S_ROUND,
        S_FINISHED
    } state_t;

    state_t             state_q, state_d;

    logic               sign_q, sign_d;
    logic [7:0]         ea_q, ea_d;
    logic [7:0]         eb_q, eb_d;
    logic [22:0]        fa_q, fa_d;
    logic [22:0]        fb_q, fb_d;
    logic [24:0]        rem_q, rem_d;
    logic [26:0]        quo_q, quo_d;
    logic [4:0]         cnt_q, cnt_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [22:0]        man_q, man_d;
    logic               is_set_q, is_set_d;
    logic [31:0]        res_q, res_d;
    logic [31:0]        y_q, y_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
`ifdef DIVIDER_FP_DBZ_EN
    logic               dbz_q, dbz_d;
    logic               dbz_pend_q, dbz_pend_d;
`endif

    // Operand classification; denormals collapse into the zero class.
    logic a_zero, a_inf, a_nan;
    logic b_zero, b_inf, b_nan;

    assign a_zero = (ea_q == 8'h00);
    assign b_zero = (eb_q == 8'h00);
    assign a_inf  = (ea_q == 8'hFF) && (fa_q == 23'h0);
    assign b_inf  = (eb_q == 8'hFF) && (fb_q == 23'h0);
    assign a_nan  = (ea_q == 8'hFF) && (fa_q != 23'h0);
    assign b_nan  = (eb_q == 8'hFF) && (fb_q != 23'h0);

    logic        special;
    logic [31:0] special_y;

    always_comb begin
        special   = 1'b1;
        special_y = NAN_VALUE;
        if (a_nan || b_nan) begin
            special_y = NAN_VALUE;
        end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
            special_y = NAN_VALUE;
        end else if (a_inf || b_zero) begin
            special_y = {sign_q, 8'hFF, 23'h0};
        end else if (a_zero || b_inf) begin
            special_y = {sign_q, 31'h0};
        end else begin
            special = 1'b0;
        end
    end

    // Restoring division step: remainder stays below 2*mant_b, so 25 bits suffice.
    logic [24:0] mant_b_ext;
    logic        div_ge;
    logic [24:0] div_diff;

    assign mant_b_ext = {2'b01, fb_q};
    assign div_ge     = (rem_q >= mant_b_ext);
    assign div_diff   = div_ge ? (rem_q - mant_b_ext) : rem_q;

    // Rounding works on the fraction only; quo_q[26] is the hidden one after NORMALIZE.
    logic              rnd_sticky;
    logic              rnd_up;
    logic [23:0]       rnd_sum;
    logic signed [9:0] rnd_exp;

    assign rnd_sticky = (|quo_q[1:0]) | (rem_q != 25'h0);
    assign rnd_up     = quo_q[2] & (rnd_sticky | quo_q[3]);
    assign rnd_sum    = {1'b0, quo_q[25:3]} + {23'h0, rnd_up};
    assign rnd_exp    = rnd_sum[23] ? (exp_q + 10'sd1) : exp_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start) state_d = S_CHECKS;
            S_CHECKS:    state_d = special ? S_FINISHED : S_DIVIDE;
            S_DIVIDE:    if (cnt_q == CNT_LAST) state_d = S_NORMALIZE;
            S_NORMALIZE: state_d = S_ROUND;
            S_ROUND:     state_d = S_FINISHED;
            S_FINISHED:  state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sign_d   = sign_q;
        ea_d     = ea_q;
        eb_d     = eb_q;
        fa_d     = fa_q;
        fb_d     = fb_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        man_d    = man_q;
        is_set_d = is_set_q;
        res_d    = res_q;
        y_d      = y_q;
        busy_d   = busy_q;
        ready_d  = 1'b0;
`ifdef DIVIDER_FP_DBZ_EN
        dbz_d      = dbz_q;
        dbz_pend_d = dbz_pend_q;
`endif
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    busy_d   = 1'b1;
                    sign_d   = A[31] ^ B[31];
                    ea_d     = A[30:23];
                    eb_d     = B[30:23];
                    fa_d     = A[22:0];
                    fb_d     = B[22:0];
                    is_set_d = 1'b0;
                end
            end
            S_CHECKS: begin
                busy_d   = 1'b1;
                is_set_d = special;
                res_d    = special_y;
                exp_d    = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127;
                rem_d    = {2'b01, fa_q};
                quo_d    = 27'h0;
                cnt_d    = 5'h0;
`ifdef DIVIDER_FP_DBZ_EN
                dbz_pend_d = b_zero & ~a_zero & ~a_inf & ~a_nan;
`endif
            end
            S_DIVIDE: begin
                rem_d = div_diff << 1;
                quo_d = {quo_q[25:0], div_ge};
                cnt_d = cnt_q + 5'd1;
            end
            S_NORMALIZE: begin
                if (!quo_q[26]) begin
                    quo_d = quo_q << 1;
                    exp_d = exp_q - 10'sd1;
                end
            end
            S_ROUND: begin
                exp_d = rnd_exp;
                man_d = rnd_sum[22:0];
                if (rnd_exp > 10'sd254) begin
                    is_set_d = 1'b1;
                    res_d    = {sign_q, 8'hFF, 23'h0};
                end else if (rnd_exp < 10'sd1) begin
                    is_set_d = 1'b1;
                    res_d    = {sign_q, 31'h0};
                end
            end
            S_FINISHED: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                y_d     = is_set_q ? res_q : {sign_q, exp_q[7:0], man_q};
`ifdef DIVIDER_FP_DBZ_EN
                dbz_d   = dbz_pend_q;
`endif
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign_q   <= 1'b0;
            ea_q     <= 8'h0;
            eb_q     <= 8'h0;
            fa_q     <= 23'h0;
            fb_q     <= 23'h0;
            rem_q    <= 25'h0;
            quo_q    <= 27'h0;
            cnt_q    <= 5'h0;
            exp_q    <= 10'sd0;
            man_q    <= 23'h0;
            is_set_q <= 1'b0;
            res_q    <= 32'h0;
            y_q      <= 32'h0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            sign_q   <= sign_d;
            ea_q     <= ea_d;
            eb_q     <= eb_d;
            fa_q     <= fa_d;
            fb_q     <= fb_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            exp_q    <= exp_d;
            man_q    <= man_d;
            is_set_q <= is_set_d;
            res_q    <= res_d;
            y_q      <= y_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

`ifdef DIVIDER_FP_DBZ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbz_q      <= 1'b0;
            dbz_pend_q <= 1'b0;
        end else begin
            dbz_q      <= dbz_d;
            dbz_pend_q <= dbz_pend_d;
        end
    end

    assign dbz = dbz_q;
`endif

    assign busy  = busy_q;
    assign ready = ready_q;
    assign Y     = y_q;

endmodule
